dino_jump_ctrl: RTL and testbench

- Jump and game-state controller for the dinosaur runner.
- Debounces the raw jump button and detects its rising edge.
- Runs a tick-based ballistic jump model that produces a 6-bit dinosaur height for the VGA/ground renderers.
- Drives the global game_status flag consumed by the ground scroller.

---
 rtl/dino_jump_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dino_jump_ctrl                                                  |
// | Brief    : Jump button debounce, tick-based ballistic jump model and game  |
// |            state control for the dinosaur runner.                          |
// | Option   : DOUBLE_JUMP_EN enables one extra jump per airborne period.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dino_jump_ctrl #(
  parameter int DEB_W    = 4,
  parameter int TICK_DIV = 500000,
  parameter int V0       = 10,
  parameter int GRAV     = 1
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       button_jump,
  input  logic       collide,
  output logic [5:0] dinosaur_height,
  output logic       game_status
);

  localparam int                   c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DEB_W-1:0]     c_DEB_MAX   = {DEB_W{1'b1}};
  localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic signed [7:0]    c_V0        = 8'(V0);
  localparam logic signed [7:0]    c_GRAV      = 8'(GRAV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GROUND = 2'd1,
    S_AIR    = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  logic                r_sync0;
  logic                r_sync1;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic                r_deb_level;
  logic                w_deb_diff;
  logic                w_deb_flip;
  logic                w_press;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_height;
  logic [5:0]          w_height_nxt;
  logic signed [7:0]   r_vel;
  logic signed [7:0]   w_vel_nxt;
  logic signed [8:0]   w_sum;
`ifdef DOUBLE_JUMP_EN
  logic                r_dj_used;
  logic                w_dj_used_nxt;
`endif

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= button_jump;
      r_sync1 <= r_sync0;
    end
  end

  assign w_deb_diff = r_sync1 ^ r_deb_level;
  assign w_deb_flip = w_deb_diff && (r_deb_cnt == c_DEB_MAX);
  assign w_press    = w_deb_flip && r_sync1;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
    end else if (w_deb_flip) begin
      r_deb_level <= ~r_deb_level;
      r_deb_cnt   <= '0;
    end else if (w_deb_diff) begin
      r_deb_cnt   <= r_deb_cnt + DEB_W'(1);
    end else begin
      r_deb_cnt   <= '0;
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  // Height is 0..63 and velocity -128..127, so 9 signed bits never overflow
  assign w_sum = $signed({3'b000, r_height}) + $signed({r_vel[7], r_vel});

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_height <= '0;
      r_vel    <= '0;
`ifdef DOUBLE_JUMP_EN
      r_dj_used <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_height <= w_height_nxt;
      r_vel    <= w_vel_nxt;
`ifdef DOUBLE_JUMP_EN
      r_dj_used <= w_dj_used_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_height_nxt = r_height;
    w_vel_nxt    = r_vel;
`ifdef DOUBLE_JUMP_EN
    w_dj_used_nxt = r_dj_used;
`endif
    if (collide && (r_state == S_GROUND || r_state == S_AIR)) begin
      w_state_nxt = S_OVER;
`ifdef DOUBLE_JUMP_EN
      w_dj_used_nxt = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_GROUND, S_OVER: begin
          if (w_press) begin
            w_state_nxt  = S_AIR;
            w_vel_nxt    = c_V0;
            w_height_nxt = '0;
          end
        end
        S_AIR: begin
`ifdef DOUBLE_JUMP_EN
          if (w_press && !r_dj_used) begin
            w_vel_nxt     = c_V0;
            w_dj_used_nxt = 1'b1;
          end else
`endif
          if (w_tick) begin
            if (r_vel[7] && (w_sum <= 9'sd0)) begin
              w_state_nxt  = S_GROUND;
              w_height_nxt = '0;
              w_vel_nxt    = '0;
`ifdef DOUBLE_JUMP_EN
              w_dj_used_nxt = 1'b0;
`endif
            end else begin
              w_height_nxt = (w_sum > 9'sd63) ? 6'd63 : w_sum[5:0];
              w_vel_nxt    = r_vel - c_GRAV;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign dinosaur_height = r_height;
  assign game_status     = (r_state == S_GROUND) || (r_state == S_AIR);

endmodule
`default_nettype wire

// File: tb/tb_dino_jump_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dino_jump_ctrl                                               |
// | Brief    : Directed self-checking bench for dino_jump_ctrl.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dino_jump_ctrl;

  localparam int c_TICK_DIV = 4;
  localparam int c_DEB_W    = 2;

  logic       CLK = 1'b0;
  logic       rst;
  logic       button_jump;
  logic       collide;
  logic [5:0] dinosaur_height;
  logic       game_status;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DOUBLE_JUMP_EN
  localparam int c_N = 27;
  int exp_air [c_N] = '{10, 19, 27, 34, 40, 50, 59, 63, 63, 63, 63, 63, 63, 63, 63,
                        63, 62, 60, 57, 53, 48, 42, 35, 27, 18, 8, 0};
`else
  localparam int c_N = 21;
  int exp_air [c_N] = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55, 54, 52, 49, 45,
                        40, 34, 27, 19, 10, 0};
`endif

  always #5 CLK = ~CLK;

  dino_jump_ctrl #(
    .DEB_W    (c_DEB_W),
    .TICK_DIV (c_TICK_DIV),
    .V0       (10),
    .GRAV     (1)
  ) u_dut (
    .CLK             (CLK),
    .rst             (rst),
    .button_jump     (button_jump),
    .collide         (collide),
    .dinosaur_height (dinosaur_height),
    .game_status     (game_status)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int hold, input int low);
    button_jump = 1'b1;
    repeat (hold) @(negedge CLK);
    button_jump = 1'b0;
    repeat (low) @(negedge CLK);
  endtask

  task automatic wait_status(input logic val, input int max_cyc, input string tag);
    int n = 0;
    while (game_status !== val && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    check(tag, int'(game_status), int'(val));
  endtask

  task automatic wait_height(input int target, input bit equal, input int max_cyc);
    int n = 0;
    while (((int'(dinosaur_height) == target) != equal) && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    button_jump = 1'b0;
    collide     = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_h", int'(dinosaur_height), 0);
    check("reset_status", int'(game_status), 0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      repeat (25) @(negedge CLK);
      check("idle_h", int'(dinosaur_height), 0);
      check("idle_status", int'(game_status), 0);
    end

    // Two-cycle glitch must not be accepted
    push(2, 20);
    check("glitch_status", int'(game_status), 0);
    check("glitch_h", int'(dinosaur_height), 0);

    // Full jump from IDLE, with extra presses while airborne
    fork push(8, 8); join_none
    wait_status(1'b1, 20, "jump1_start");
    wait_height(0, 1'b0, 16);
    check("air_h0", int'(dinosaur_height), exp_air[0]);
    for (int i = 1; i < c_N; i++) begin
      repeat (c_TICK_DIV) @(negedge CLK);
      check($sformatf("air_h%0d", i), int'(dinosaur_height), exp_air[i]);
      if (i == 3 || i == 9) begin
        fork push(8, 8); join_none
      end
    end
    check("land1_status", int'(game_status), 1);

    // Collision at height 34, then restart from OVER
    repeat (8) @(negedge CLK);
    fork push(8, 8); join_none
    wait_status(1'b1, 20, "jump2_start");
    wait_height(0, 1'b0, 16);
    repeat (3 * c_TICK_DIV) @(negedge CLK);
    check("pre_collide_h", int'(dinosaur_height), 34);
    collide = 1'b1;
    @(negedge CLK);
    collide = 1'b0;
    check("over_status", int'(game_status), 0);
    check("over_h", int'(dinosaur_height), 34);
    repeat (12) @(negedge CLK);
    check("over_hold_h", int'(dinosaur_height), 34);
    fork push(8, 8); join_none
    wait_status(1'b1, 20, "restart_status");
    check("restart_h0", int'(dinosaur_height), 0);
    wait_height(0, 1'b0, 16);
    check("restart_h1", int'(dinosaur_height), 10);
    wait_height(0, 1'b1, 200);
    check("land2_h", int'(dinosaur_height), 0);
    check("land2_status", int'(game_status), 1);

    // Collide and press pulse in the same cycle while GROUND
    repeat (4) @(negedge CLK);
    button_jump = 1'b1;
    repeat (5) @(negedge CLK);
    collide = 1'b1;
    @(negedge CLK);
    collide     = 1'b0;
    button_jump = 1'b0;
    check("coll_press_status", int'(game_status), 0);
    check("coll_press_h", int'(dinosaur_height), 0);
    repeat (12) @(negedge CLK);
    check("coll_press_hold", int'(game_status), 0);

    // Reset in mid-air
    fork push(8, 8); join_none
    wait_status(1'b1, 20, "jump4_start");
    wait_height(0, 1'b0, 16);
    repeat (2 * c_TICK_DIV) @(negedge CLK);
    check("mid_h", int'(dinosaur_height), 27);
    rst = 1'b1;
    @(negedge CLK);
    check("rst_mid_h", int'(dinosaur_height), 0);
    check("rst_mid_status", int'(game_status), 0);
    rst = 1'b0;
    repeat (20) @(negedge CLK);
    check("post_rst_idle", int'(game_status), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
